// File: rtl/fnd_digit_scanner.sv
// Time-multiplexed N-digit 7-segment driver: steps one digit per divider edge,
// blanks between digits and snapshots BCD data once per frame.
module fnd_digit_scanner #(
  parameter int N_DIGIT        = 4,
  parameter int BLANK_CYCLES   = 2,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_digit_clk,
  input  logic                 i_enable,
  input  logic                 i_lzb,
  input  logic [4*N_DIGIT-1:0] i_bcd,
  input  logic [N_DIGIT-1:0]   i_dp,
  output logic [N_DIGIT-1:0]   o_fnd_com,
  output logic [7:0]           o_fnd_font,
  output logic                 o_frame_tick
);

  localparam int IW = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGIT - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  // Reset asserts immediately but is released only on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_pipe <= '0;
    else            rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Divider output is treated as data: synchronize, then detect rising edge.
  logic sync1, sync2, prev;
  logic adv;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= i_digit_clk;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign adv = sync2 & ~prev;

  state_t              state_q, state_d;
  logic [IW-1:0]       index_q, index_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                take_snap;
  logic [4*N_DIGIT-1:0] snap_bcd;
  logic [N_DIGIT-1:0]  snap_dp;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    take_snap = 1'b0;
    unique case (state_q)
      IDLE, SHOW: begin
        if (adv) begin
          state_d   = BLANK;
          index_d   = (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
          cnt_d     = 8'(BLANK_CYCLES - 1);
          take_snap = (index_d == '0);
        end
      end
      BLANK: begin
        // Advance requests landing here are intentionally dropped.
        if (cnt_q == 8'd0) state_d = SHOW;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      index_q <= LAST_IDX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset to a
  // known value like any other state.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_bcd <= '0;
      snap_dp  <= '0;
    end else if (take_snap) begin
      snap_bcd <= i_bcd;
      snap_dp  <= i_dp;
    end
  end

  function automatic logic [6:0] encode(input logic [3:0] bcd);
    unique case (bcd)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h40;
    endcase
  endfunction

  // lead_zero[k]: digit k and every digit above it are 0 with no dp set.
  logic [N_DIGIT-1:0] lead_zero;
  logic               run_zero;

  always_comb begin
    lead_zero = '0;
    run_zero  = 1'b1;
    for (int k = N_DIGIT - 1; k >= 0; k--) begin
      run_zero     = run_zero & (snap_bcd[4*k +: 4] == 4'd0) & ~snap_dp[k];
      lead_zero[k] = run_zero;
    end
  end

  logic [3:0]         sel_bcd;
  logic               sel_dp;
  logic               lz_blank;
  logic               show;
  logic [N_DIGIT-1:0] com_act;
  logic [7:0]         font_act;

  always_comb begin
    sel_bcd  = snap_bcd[{index_q, 2'b00} +: 4];
    sel_dp   = snap_dp[index_q];
    lz_blank = i_lzb && (index_q != '0) && lead_zero[index_q];
    show     = (state_d == SHOW) && i_enable;
    com_act  = show ? (N_DIGIT'(1) << index_q) : '0;
    font_act = (show && !lz_blank) ? {sel_dp, encode(sel_bcd)} : 8'h00;
  end

  // Outputs are registered from next-state values; polarity is applied last.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fnd_com    <= {N_DIGIT{COM_ACTIVE_LOW}};
      o_fnd_font   <= {8{SEG_ACTIVE_LOW}};
      o_frame_tick <= 1'b0;
    end else begin
      o_fnd_com    <= com_act ^ {N_DIGIT{COM_ACTIVE_LOW}};
      o_fnd_font   <= font_act ^ {8{SEG_ACTIVE_LOW}};
      o_frame_tick <= take_snap;
    end
  end

endmodule

// File: tb/tb_fnd_digit_scanner.sv
// Directed bench for fnd_digit_scanner (4 digits, 2 dead cycles, active-low outputs).
module tb_fnd_digit_scanner;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_digit_clk;
  logic        i_enable;
  logic        i_lzb;
  logic [15:0] i_bcd;
  logic [3:0]  i_dp;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_font;
  logic        o_frame_tick;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] last_com;
  logic [7:0] last_font;

  fnd_digit_scanner #(
    .N_DIGIT(4), .BLANK_CYCLES(2), .COM_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_digit_clk(i_digit_clk),
    .i_enable(i_enable), .i_lzb(i_lzb), .i_bcd(i_bcd), .i_dp(i_dp),
    .o_fnd_com(o_fnd_com), .o_fnd_font(o_fnd_font), .o_frame_tick(o_frame_tick)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One digit step: rising divider edge, hold check, two dead cycles, new digit.
  task automatic step(input string tag, input logic exp_tick,
                      input logic [3:0] exp_com, input logic [7:0] exp_font);
    @(negedge i_clk) i_digit_clk = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check({tag, " hold com"}, 32'(o_fnd_com), 32'(last_com));
    @(negedge i_clk);
    i_digit_clk = 1'b0;
    check({tag, " dead1 com"},  32'(o_fnd_com),    32'h0F);
    check({tag, " dead1 font"}, 32'(o_fnd_font),   32'hFF);
    check({tag, " tick"},       32'(o_frame_tick), 32'(exp_tick));
    @(negedge i_clk);
    check({tag, " dead2 com"},  32'(o_fnd_com),    32'h0F);
    check({tag, " dead2 font"}, 32'(o_fnd_font),   32'hFF);
    check({tag, " tick off"},   32'(o_frame_tick), 32'h0);
    @(negedge i_clk);
    check({tag, " com"},  32'(o_fnd_com),  32'(exp_com));
    check({tag, " font"}, 32'(o_fnd_font), 32'(exp_font));
    last_com  = exp_com;
    last_font = exp_font;
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_digit_clk = 1'b0;
    i_enable    = 1'b1;
    i_lzb       = 1'b0;
    i_bcd       = 16'h1234;
    i_dp        = 4'b0000;
    last_com    = 4'hF;
    last_font   = 8'hFF;

    repeat (3) @(negedge i_clk);
    check("reset com",  32'(o_fnd_com),    32'h0F);
    check("reset font", 32'(o_fnd_font),   32'hFF);
    check("reset tick", 32'(o_frame_tick), 32'h0);
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_clk);
    check("idle com", 32'(o_fnd_com), 32'h0F);

    // Basic scan of 1234 with wrap.
    step("t1 d0", 1'b1, 4'b1110, 8'h99);
    step("t1 d1", 1'b0, 4'b1101, 8'hB0);
    step("t1 d2", 1'b0, 4'b1011, 8'hA4);
    step("t1 d3", 1'b0, 4'b0111, 8'hF9);
    step("t1 wrap", 1'b1, 4'b1110, 8'h99);

    // Tear-free frame: data change at index 1 waits for next digit 0.
    step("t4 d1", 1'b0, 4'b1101, 8'hB0);
    i_bcd = 16'h5678;
    step("t4 d2 old", 1'b0, 4'b1011, 8'hA4);
    step("t4 d3 old", 1'b0, 4'b0111, 8'hF9);
    step("t4 d0 new", 1'b1, 4'b1110, 8'h80);
    step("t4 d1 new", 1'b0, 4'b1101, 8'hF8);

    // Leading-zero blanking.
    i_bcd = 16'h0007;
    i_lzb = 1'b1;
    step("t3 d2 old", 1'b0, 4'b1011, 8'h82);
    step("t3 d3 old", 1'b0, 4'b0111, 8'h92);
    step("t3 d0", 1'b1, 4'b1110, 8'hF8);
    step("t3 d1 lz", 1'b0, 4'b1101, 8'hFF);
    step("t3 d2 lz", 1'b0, 4'b1011, 8'hFF);
    step("t3 d3 lz", 1'b0, 4'b0111, 8'hFF);
    i_dp = 4'b0010;
    step("t3 dp d0", 1'b1, 4'b1110, 8'hF8);
    step("t3 dp d1", 1'b0, 4'b1101, 8'h40);
    step("t3 dp d2", 1'b0, 4'b1011, 8'hFF);
    step("t3 dp d3", 1'b0, 4'b0111, 8'hFF);

    // Dash encoding and zero mid-number.
    i_bcd = 16'hF0A9;
    i_dp  = 4'b0000;
    i_lzb = 1'b0;
    step("t5 d0", 1'b1, 4'b1110, 8'h90);
    step("t5 d1", 1'b0, 4'b1101, 8'hBF);
    step("t5 d2", 1'b0, 4'b1011, 8'hC0);
    step("t5 d3", 1'b0, 4'b0111, 8'hBF);

    // Two divider edges close together: the second lands in BLANK and is dropped.
    @(negedge i_clk) i_digit_clk = 1'b1;
    @(negedge i_clk) i_digit_clk = 1'b0;
    @(negedge i_clk) i_digit_clk = 1'b1;
    @(negedge i_clk) i_digit_clk = 1'b0;
    check("t5 dbl tick", 32'(o_frame_tick), 32'h1);
    check("t5 dbl dead", 32'(o_fnd_com), 32'h0F);
    repeat (2) @(negedge i_clk);
    check("t5 dbl com",  32'(o_fnd_com),  32'hE);
    check("t5 dbl font", 32'(o_fnd_font), 32'h90);
    repeat (3) @(negedge i_clk);
    check("t5 dbl hold", 32'(o_fnd_com), 32'hE);
    last_com  = 4'b1110;
    last_font = 8'h90;
    step("t5 after dbl", 1'b0, 4'b1101, 8'hBF);

    // Enable gating: dark while scan keeps moving, resume on current index.
    @(negedge i_clk) i_enable = 1'b0;
    @(negedge i_clk);
    check("t6 en off com",  32'(o_fnd_com),  32'h0F);
    check("t6 en off font", 32'(o_fnd_font), 32'hFF);
    last_com  = 4'hF;
    last_font = 8'hFF;
    step("t6 dark d2", 1'b0, 4'hF, 8'hFF);
    i_enable = 1'b1;
    @(negedge i_clk);
    check("t6 resume com",  32'(o_fnd_com),  32'hB);
    check("t6 resume font", 32'(o_fnd_font), 32'hC0);

    // Asynchronous reset mid-SHOW at index 2.
    #2 i_reset_n = 1'b0;
    #1;
    check("t6 rst com",  32'(o_fnd_com),  32'h0F);
    check("t6 rst font", 32'(o_fnd_font), 32'hFF);
    i_bcd = 16'h1234;
    @(negedge i_clk) i_reset_n = 1'b1;
    repeat (5) @(negedge i_clk);
    check("t6 post rst com", 32'(o_fnd_com), 32'h0F);
    last_com  = 4'hF;
    last_font = 8'hFF;
    step("t6 restart d0", 1'b1, 4'b1110, 8'h99);
    step("t6 restart d1", 1'b0, 4'b1101, 8'hB0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
